shift_register_universal: RTL and testbench

SHIFT_REGISTER_UNIVERSAL -- requirements
Module: shift_register_universal

---
 rtl/shift_register_universal_if.sv | 32 +++
 rtl/shift_register_universal.sv | 112 +++++++++++
 tb/tb_shift_register_universal.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_register_universal_if.sv
// Control/data bundle for the universal shift register: the master drives the
// requests and load data, the slave returns the register contents and burst status.
interface shift_register_universal_if #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) ();

    logic             en;
    logic             load;
    logic [2:0]       mode;
    logic [STEP-1:0]  serial_in;
    logic [WIDTH-1:0] parallel_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] parallel_out;
    logic [STEP-1:0]  serial_out_r;
    logic [STEP-1:0]  serial_out_l;
    logic             busy;
    logic             done;

    modport master (
        output en, load, mode, serial_in, parallel_in, start, count,
        input  parallel_out, serial_out_r, serial_out_l, busy, done
    );

    modport slave (
        input  en, load, mode, serial_in, parallel_in, start, count,
        output parallel_out, serial_out_r, serial_out_l, busy, done
    );

endinterface

// File: rtl/shift_register_universal.sv
// Universal shift register: single steps while idle, or counted bursts that
// latch their mode at start and can be stalled with en or aborted by load.
module shift_register_universal #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    shift_register_universal_if.slave  bus
);

    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_LSL = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ASR = 3'b101;

    if ((STEP < 1) || (STEP > WIDTH) || ((WIDTH % STEP) != 0)) begin : g_bad_step
        $error("shift_register_universal: STEP must divide WIDTH and lie in 1..WIDTH");
    end

    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [2:0]       mode_q, mode_d;

    // Shifts are built on a WIDTH+STEP concatenation so STEP == WIDTH needs no special case.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [WIDTH-1:0] v,
        input logic [2:0]       m,
        input logic [STEP-1:0]  si
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            MODE_LSR: r = WIDTH'({si, v} >> STEP);
            MODE_LSL: r = WIDTH'({v, si});
            MODE_ROR: r = WIDTH'({v[STEP-1:0], v} >> STEP);
            MODE_ROL: r = WIDTH'({v, v[WIDTH-1 -: STEP]});
            MODE_ASR: r = WIDTH'({{STEP{v[WIDTH-1]}}, v} >> STEP);
            default:  r = v;
        endcase
        return r;
    endfunction

    // Next-state selection in priority order: load, start accept, burst step, idle step.
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (bus.load) begin
            data_d = bus.parallel_in;
            busy_d = 1'b0;
            cnt_d  = {CNT_W{1'b0}};
        end else if (bus.start && !busy_q) begin
            mode_d = bus.mode;
            cnt_d  = bus.count;
            if (bus.count == {CNT_W{1'b0}}) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else if (busy_q) begin
            if (bus.en) begin
                data_d = step_fn(data_q, mode_q, bus.serial_in);
                cnt_d  = cnt_q - CNT_W'(1);
                // A zero count while busy cannot occur normally; treat it as the last step.
                if (cnt_q <= CNT_W'(1)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end else begin
                data_d = data_q;
            end
        end else if (bus.en) begin
            data_d = step_fn(data_q, bus.mode, bus.serial_in);
        end else begin
            data_d = data_q;
        end
    end

    // State registers with synchronous reset overriding every request.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {WIDTH{1'b0}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            mode_q <= 3'b000;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign bus.parallel_out = data_q;
    assign bus.serial_out_r = data_q[STEP-1:0];
    assign bus.serial_out_l = data_q[WIDTH-1 -: STEP];
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Drives a STEP=1 and a STEP=2 instance with identical control and checks both
// against an arithmetic reference model plus directed constant expectations.
module tb_shift_register_universal;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, load = 1'b0, start = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [3:0] count = 4'd0;
    logic [7:0] pin = 8'h00;
    logic       si1 = 1'b0;
    logic [1:0] si2 = 2'b00;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m_val  [2];
    logic       m_busy [2];
    logic       m_done [2];
    int         m_rem  [2];
    logic [2:0] m_mode [2];

    always #5 clk = ~clk;

    shift_register_universal_if #(.WIDTH(8), .STEP(1), .CNT_W(4)) bus1 ();
    shift_register_universal_if #(.WIDTH(8), .STEP(2), .CNT_W(4)) bus2 ();

    assign bus1.en = en;   assign bus1.load = load; assign bus1.mode = mode;
    assign bus1.start = start; assign bus1.count = count; assign bus1.parallel_in = pin;
    assign bus1.serial_in = si1;
    assign bus2.en = en;   assign bus2.load = load; assign bus2.mode = mode;
    assign bus2.start = start; assign bus2.count = count; assign bus2.parallel_in = pin;
    assign bus2.serial_in = si2;

    shift_register_universal #(.WIDTH(8), .STEP(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    shift_register_universal #(.WIDTH(8), .STEP(2), .CNT_W(4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    // Reference step: shifts and rotates written as plain arithmetic on the value.
    function automatic logic [7:0] ref_step(logic [7:0] v, logic [2:0] m, int s, logic [1:0] si);
        logic [7:0] siw;
        siw = {6'b000000, si};
        case (m)
            3'd1:    return (v >> s) | (siw << (8 - s));
            3'd2:    return (v << s) | siw;
            3'd3:    return (v >> s) | (v << (8 - s));
            3'd4:    return (v << s) | (v >> (8 - s));
            3'd5:    return 8'($signed(v) >>> s);
            default: return v;
        endcase
    endfunction

    task automatic model_edge(int k);
        int         s;
        logic [1:0] si;
        s  = k + 1;
        si = (k == 0) ? {1'b0, si1} : si2;
        m_done[k] = 1'b0;
        if (rst) begin
            m_val[k] = 8'h00; m_busy[k] = 1'b0; m_rem[k] = 0; m_mode[k] = 3'b000;
        end else if (load) begin
            m_val[k] = pin; m_busy[k] = 1'b0; m_rem[k] = 0;
        end else if (start && !m_busy[k]) begin
            m_mode[k] = mode;
            m_rem[k]  = int'(count);
            m_busy[k] = (count != 4'd0);
            m_done[k] = (count == 4'd0);
        end else if (m_busy[k]) begin
            if (en) begin
                m_val[k] = ref_step(m_val[k], m_mode[k], s, si);
                m_rem[k] = m_rem[k] - 1;
                if (m_rem[k] == 0) begin
                    m_busy[k] = 1'b0; m_done[k] = 1'b1;
                end
            end
        end else if (en) begin
            m_val[k] = ref_step(m_val[k], mode, s, si);
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("po1",   32'(bus1.parallel_out), 32'(m_val[0]));
        chk("busy1", 32'(bus1.busy),         32'(m_busy[0]));
        chk("done1", 32'(bus1.done),         32'(m_done[0]));
        chk("sor1",  32'(bus1.serial_out_r), 32'(m_val[0] & 8'h01));
        chk("sol1",  32'(bus1.serial_out_l), 32'(m_val[0] >> 7));
        chk("po2",   32'(bus2.parallel_out), 32'(m_val[1]));
        chk("busy2", 32'(bus2.busy),         32'(m_busy[1]));
        chk("done2", 32'(bus2.done),         32'(m_done[1]));
        chk("sor2",  32'(bus2.serial_out_r), 32'(m_val[1] & 8'h03));
        chk("sol2",  32'(bus2.serial_out_l), 32'(m_val[1] >> 6));
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic quiet();
        rst = 1'b0; en = 1'b0; load = 1'b0; start = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        int done_pulses;
        logic [7:0] saved;
        logic en_pat [6];
        logic st_pat [6];
        en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        st_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // reset, with every other request active
        rst = 1'b1; load = 1'b1; start = 1'b1; en = 1'b1; pin = 8'hFF;
        tick();
        chk("rst_po",   32'(bus1.parallel_out), 32'h0);
        chk("rst_busy", 32'(bus1.busy), 32'h0);
        chk("rst_done", 32'(bus2.done), 32'h0);

        // logical right with serial_in=1
        quiet(); load = 1'b1; pin = 8'hA5; tick();
        quiet(); mode = 3'b001; si1 = 1'b1; si2 = 2'b11; en = 1'b1; tick();
        chk("lsr_po",  32'(bus1.parallel_out), 32'hD2);
        chk("lsr_sor", 32'(bus1.serial_out_r), 32'h0);

        // arithmetic right x3 then rotate right x1
        quiet(); load = 1'b1; pin = 8'h81; tick();
        quiet(); mode = 3'b101; en = 1'b1; tick(); tick(); tick();
        chk("asr_po", 32'(bus1.parallel_out), 32'hF0);
        quiet(); load = 1'b1; pin = 8'h81; tick();
        quiet(); mode = 3'b011; en = 1'b1; tick();
        chk("ror_po", 32'(bus1.parallel_out), 32'hC0);

        // 3-step rotate-left burst on the STEP=2 instance; mode changed mid-burst
        quiet(); load = 1'b1; pin = 8'h1B; tick();
        quiet(); start = 1'b1; mode = 3'b100; count = 4'd3; en = 1'b1; tick();
        start = 1'b0; mode = 3'b001; count = 4'd9;
        busy_cycles = 0;
        for (int i = 0; i < 20 && bus2.busy === 1'b1; i++) begin
            busy_cycles++;
            tick();
        end
        chk("b3_busy_cycles", 32'(busy_cycles), 32'd3);
        chk("b3_po",   32'(bus2.parallel_out), 32'hC6);
        chk("b3_done", 32'(bus2.done), 32'h1);
        en = 1'b0; tick();
        chk("b3_done_drop", 32'(bus2.done), 32'h0);
        chk("b3_idle", 32'(bus2.busy), 32'h0);

        // 4-step burst stalled 2 cycles, start re-asserted while busy
        quiet(); load = 1'b1; pin = 8'h96; tick();
        quiet(); start = 1'b1; mode = 3'b010; count = 4'd4; en = 1'b1; si1 = 1'b1; si2 = 2'b01; tick();
        busy_cycles = (bus1.busy === 1'b1) ? 1 : 0;
        done_pulses = 0;
        for (int j = 0; j < 6; j++) begin
            en = en_pat[j]; start = st_pat[j]; count = 4'd7;
            tick();
            if (bus1.busy === 1'b1) busy_cycles++;
            if (bus1.done === 1'b1) done_pulses++;
        end
        quiet(); tick();
        if (bus1.done === 1'b1) done_pulses++;
        chk("b4_busy_cycles", 32'(busy_cycles), 32'd6);
        chk("b4_done_pulses", 32'(done_pulses), 32'd1);
        chk("b4_po", 32'(bus1.parallel_out), 32'h6F);

        // zero-count start
        saved = bus1.parallel_out;
        quiet(); start = 1'b1; count = 4'd0; mode = 3'b011; en = 1'b1; tick();
        chk("c0_done", 32'(bus1.done), 32'h1);
        chk("c0_busy", 32'(bus1.busy), 32'h0);
        chk("c0_po",   32'(bus1.parallel_out), 32'(saved));
        quiet(); tick();
        chk("c0_done_drop", 32'(bus1.done), 32'h0);

        // load aborts a burst without done
        quiet(); start = 1'b1; count = 4'd5; mode = 3'b001; tick();
        quiet(); en = 1'b1; tick();
        load = 1'b1; pin = 8'h3C; tick();
        chk("ab_po",   32'(bus1.parallel_out), 32'h3C);
        chk("ab_busy", 32'(bus1.busy), 32'h0);
        chk("ab_done", 32'(bus1.done), 32'h0);
        quiet(); tick();
        chk("ab_done_after", 32'(bus1.done), 32'h0);

        // reset mid-burst beats load and start; next idle step uses the mode input
        quiet(); start = 1'b1; count = 4'd5; mode = 3'b100; tick();
        quiet(); en = 1'b1; tick();
        rst = 1'b1; load = 1'b1; start = 1'b1; pin = 8'hEE; tick();
        chk("rb_po",   32'(bus2.parallel_out), 32'h0);
        chk("rb_busy", 32'(bus2.busy), 32'h0);
        chk("rb_done", 32'(bus2.done), 32'h0);
        quiet(); mode = 3'b010; si1 = 1'b1; si2 = 2'b11; en = 1'b1; tick();
        chk("rb_step1", 32'(bus1.parallel_out), 32'h01);
        chk("rb_step2", 32'(bus2.parallel_out), 32'h03);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 6) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = 3'($urandom_range(0, 7));
            count = 4'($urandom_range(0, 15));
            pin   = 8'($urandom);
            si1   = 1'($urandom);
            si2   = 2'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
